// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard unit: per-stage stall/smash, operand forwarding selects and long-latency scoreboard.
// Define HAZARD_FORWARDING_EN to forward from EX/MEM/WB instead of stalling on RAW matches.
module pipeline_hazard_scoreboard #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int ADDRESS_WIDTH  = 32,
   parameter int CNT_WIDTH      = 2
) (
   input  logic                      i_Clk,
   input  logic                      i_Reset_n,
   input  logic                      i_External_Stall,
   input  logic                      i_DEC_Uses_RS,
   input  logic                      i_DEC_Uses_RT,
   input  logic [REG_ADDR_WIDTH-1:0] i_DEC_RS_Addr,
   input  logic [REG_ADDR_WIDTH-1:0] i_DEC_RT_Addr,
   input  logic                      i_DEC_Branch_Instruction,
   input  logic                      i_DEC_Long_Latency,
   input  logic [REG_ADDR_WIDTH-1:0] i_DEC_Write_Addr,
   input  logic                      i_IF_Done,
   input  logic                      i_EX_Writes_Back,
   input  logic                      i_EX_Uses_Mem,
   input  logic [REG_ADDR_WIDTH-1:0] i_EX_Write_Addr,
   input  logic                      i_EX_Branch,
   input  logic [ADDRESS_WIDTH-1:0]  i_EX_Branch_Target,
   input  logic                      i_MEM_Writes_Back,
   input  logic                      i_MEM_Done,
   input  logic [REG_ADDR_WIDTH-1:0] i_MEM_Write_Addr,
   input  logic                      i_WB_Writes_Back,
   input  logic [REG_ADDR_WIDTH-1:0] i_WB_Write_Addr,
   input  logic                      i_Retire_Valid,
   input  logic [REG_ADDR_WIDTH-1:0] i_Retire_Addr,
   output logic                      o_IF_Branch,
   output logic [ADDRESS_WIDTH-1:0]  o_IF_Branch_Target,
   output logic                      o_IF_Stall,
   output logic                      o_IF_Smash,
   output logic                      o_DEC_Stall,
   output logic                      o_DEC_Smash,
   output logic                      o_EX_Stall,
   output logic                      o_EX_Smash,
   output logic                      o_MEM_Stall,
   output logic                      o_MEM_Smash,
   output logic                      o_WB_Stall,
   output logic                      o_WB_Smash,
   output logic [1:0]                o_Fwd_RS_Sel,
   output logic [1:0]                o_Fwd_RT_Sel,
   output logic                      o_Scoreboard_Busy
);

   localparam int NREG = 2 ** REG_ADDR_WIDTH;

   logic [CNT_WIDTH-1:0]     cnt [NREG];
   logic [NREG-1:0]          inc_vec;
   logic [NREG-1:0]          dec_vec;
   logic                     inc_en;
   logic                     dec_en;
   logic                     pend_smash;
   logic                     br_latch;
   logic [ADDRESS_WIDTH-1:0] br_target;

   logic rs_used, rt_used;
   logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
   logic load_use, sb_hit, ll_full, br_wait, raw;
   logic dec_hazard;

   // Register 0 is hardwired, so it never matches a producer.
   assign rs_used = i_DEC_Uses_RS && (i_DEC_RS_Addr != '0);
   assign rt_used = i_DEC_Uses_RT && (i_DEC_RT_Addr != '0);

   assign ex_rs  = rs_used && i_EX_Writes_Back  && (i_EX_Write_Addr  == i_DEC_RS_Addr);
   assign ex_rt  = rt_used && i_EX_Writes_Back  && (i_EX_Write_Addr  == i_DEC_RT_Addr);
   assign mem_rs = rs_used && i_MEM_Writes_Back && (i_MEM_Write_Addr == i_DEC_RS_Addr);
   assign mem_rt = rt_used && i_MEM_Writes_Back && (i_MEM_Write_Addr == i_DEC_RT_Addr);
   assign wb_rs  = rs_used && i_WB_Writes_Back  && (i_WB_Write_Addr  == i_DEC_RS_Addr);
   assign wb_rt  = rt_used && i_WB_Writes_Back  && (i_WB_Write_Addr  == i_DEC_RT_Addr);

   assign load_use = i_EX_Uses_Mem && (ex_rs || ex_rt);
   assign sb_hit   = (rs_used && (cnt[i_DEC_RS_Addr] != '0))
                  || (rt_used && (cnt[i_DEC_RT_Addr] != '0));
   assign ll_full  = i_DEC_Long_Latency && (i_DEC_Write_Addr != '0)
                  && (&cnt[i_DEC_Write_Addr]);
   assign br_wait  = i_DEC_Branch_Instruction && !i_IF_Done;

`ifdef HAZARD_FORWARDING_EN
   assign raw = 1'b0;

   // Youngest producer wins; a load in EX has no data yet.
   always_comb begin
      o_Fwd_RS_Sel = 2'b00;
      if (ex_rs && !i_EX_Uses_Mem) o_Fwd_RS_Sel = 2'b01;
      else if (mem_rs)             o_Fwd_RS_Sel = 2'b10;
      else if (wb_rs)              o_Fwd_RS_Sel = 2'b11;
   end

   always_comb begin
      o_Fwd_RT_Sel = 2'b00;
      if (ex_rt && !i_EX_Uses_Mem) o_Fwd_RT_Sel = 2'b01;
      else if (mem_rt)             o_Fwd_RT_Sel = 2'b10;
      else if (wb_rt)              o_Fwd_RT_Sel = 2'b11;
   end
`else
   assign raw = ex_rs || ex_rt || mem_rs || mem_rt || wb_rs || wb_rt;
   assign o_Fwd_RS_Sel = 2'b00;
   assign o_Fwd_RT_Sel = 2'b00;
`endif

   assign o_WB_Stall  = i_External_Stall;
   assign o_WB_Smash  = i_External_Stall;
   assign o_MEM_Stall = i_External_Stall || !i_MEM_Done;
   assign o_MEM_Smash = o_MEM_Stall;
   assign o_EX_Stall  = o_MEM_Stall;
   assign o_EX_Smash  = i_External_Stall;

   assign dec_hazard  = i_External_Stall || br_wait || load_use
                     || sb_hit || ll_full || raw;
   assign o_DEC_Stall = dec_hazard || o_EX_Stall;
   assign o_DEC_Smash = dec_hazard;

   assign o_IF_Stall = i_External_Stall || o_DEC_Stall || !i_IF_Done;
   assign o_IF_Smash = i_External_Stall || i_EX_Branch || !i_IF_Done
                    || pend_smash;

   assign o_IF_Branch        = i_EX_Branch || br_latch;
   assign o_IF_Branch_Target = i_EX_Branch ? i_EX_Branch_Target : br_target;

   // A retire against an empty entry is spurious and dropped.
   assign inc_en = i_DEC_Long_Latency && (i_DEC_Write_Addr != '0)
                && !o_DEC_Stall && !o_DEC_Smash;
   assign dec_en = i_Retire_Valid && (i_Retire_Addr != '0)
                && (cnt[i_Retire_Addr] != '0) && !i_External_Stall;

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (inc_en) inc_vec[i_DEC_Write_Addr] = 1'b1;
      if (dec_en) dec_vec[i_Retire_Addr]    = 1'b1;
   end

   always_comb begin
      o_Scoreboard_Busy = 1'b0;
      for (int i = 0; i < NREG; i++)
         if (cnt[i] != '0) o_Scoreboard_Busy = 1'b1;
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (inc_vec[i] && !dec_vec[i])
               cnt[i] <= cnt[i] + CNT_WIDTH'(1);
            else if (dec_vec[i] && !inc_vec[i])
               cnt[i] <= cnt[i] - CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         pend_smash <= 1'b0;
         br_latch   <= 1'b0;
         br_target  <= '0;
      end else begin
         if (i_IF_Done)
            pend_smash <= 1'b0;
         else if (i_EX_Branch)
            pend_smash <= 1'b1;
         // Hold the redirect until IF can accept it.
         if (i_EX_Branch && o_IF_Stall) begin
            br_latch  <= 1'b1;
            br_target <= i_EX_Branch_Target;
         end else if (!o_IF_Stall) begin
            br_latch <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Directed bench for pipeline_hazard_scoreboard: vector table plus multi-cycle sequences.
// Expectations follow HAZARD_FORWARDING_EN when it is defined.
module tb_pipeline_hazard_scoreboard;

`ifdef HAZARD_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ext_stall, uses_rs, uses_rt, dec_br, dec_ll, if_done;
   logic [4:0]  rs_addr, rt_addr, dec_wa, ex_wa, mem_wa, wb_wa, ret_a;
   logic        ex_wb, ex_mem, ex_br, mem_wb, mem_done, wb_wb, ret_v;
   logic [31:0] ex_tgt;
   logic        if_branch;
   logic [31:0] if_tgt;
   logic        if_stall, if_smash, dec_stall, dec_smash, ex_stall, ex_smash;
   logic        mem_stall, mem_smash, wb_stall, wb_smash, busy;
   logic [1:0]  fwd_rs, fwd_rt;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   pipeline_hazard_scoreboard dut (
      .i_Clk                    (clk),
      .i_Reset_n                (rst_n),
      .i_External_Stall         (ext_stall),
      .i_DEC_Uses_RS            (uses_rs),
      .i_DEC_Uses_RT            (uses_rt),
      .i_DEC_RS_Addr            (rs_addr),
      .i_DEC_RT_Addr            (rt_addr),
      .i_DEC_Branch_Instruction (dec_br),
      .i_DEC_Long_Latency       (dec_ll),
      .i_DEC_Write_Addr         (dec_wa),
      .i_IF_Done                (if_done),
      .i_EX_Writes_Back         (ex_wb),
      .i_EX_Uses_Mem            (ex_mem),
      .i_EX_Write_Addr          (ex_wa),
      .i_EX_Branch              (ex_br),
      .i_EX_Branch_Target       (ex_tgt),
      .i_MEM_Writes_Back        (mem_wb),
      .i_MEM_Done               (mem_done),
      .i_MEM_Write_Addr         (mem_wa),
      .i_WB_Writes_Back         (wb_wb),
      .i_WB_Write_Addr          (wb_wa),
      .i_Retire_Valid           (ret_v),
      .i_Retire_Addr            (ret_a),
      .o_IF_Branch              (if_branch),
      .o_IF_Branch_Target       (if_tgt),
      .o_IF_Stall               (if_stall),
      .o_IF_Smash               (if_smash),
      .o_DEC_Stall              (dec_stall),
      .o_DEC_Smash              (dec_smash),
      .o_EX_Stall               (ex_stall),
      .o_EX_Smash               (ex_smash),
      .o_MEM_Stall              (mem_stall),
      .o_MEM_Smash              (mem_smash),
      .o_WB_Stall               (wb_stall),
      .o_WB_Smash               (wb_smash),
      .o_Fwd_RS_Sel             (fwd_rs),
      .o_Fwd_RT_Sel             (fwd_rt),
      .o_Scoreboard_Busy        (busy)
   );

   typedef struct {
      logic       ext, urs, urt, br, ifd, exw, exm, exb, mw, md, ww;
      logic [4:0] rs, rt, exa, ma, wa;
      logic [14:0] exp;
   } vec_t;

   vec_t vecs[$];
   vec_t d, t;

   function automatic logic [14:0] e(
      input logic ifs, ifm, ds, dm, xs, xm, ms, mm, ws, wm, br,
      input logic [1:0] rs, rt);
      return {ifs, ifm, ds, dm, xs, xm, ms, mm, ws, wm, br, rs, rt};
   endfunction

   function automatic logic [14:0] got();
      return {if_stall, if_smash, dec_stall, dec_smash, ex_stall, ex_smash,
              mem_stall, mem_smash, wb_stall, wb_smash, if_branch,
              fwd_rs, fwd_rt};
   endfunction

   task automatic chk(input string nm, input logic [31:0] g,
                      input logic [31:0] x);
      nvec++;
      if (g !== x) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", nm, g, x);
      end
   endtask

   task automatic apply(input vec_t v);
      ext_stall = v.ext; uses_rs = v.urs; uses_rt = v.urt;
      rs_addr = v.rs; rt_addr = v.rt; dec_br = v.br; if_done = v.ifd;
      ex_wb = v.exw; ex_mem = v.exm; ex_wa = v.exa; ex_br = v.exb;
      mem_wb = v.mw; mem_done = v.md; mem_wa = v.ma;
      wb_wb = v.ww; wb_wa = v.wa;
      dec_ll = 1'b0; dec_wa = '0; ret_v = 1'b0; ret_a = '0;
      ex_tgt = 32'h40;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      d = '{ext:0, urs:0, urt:0, br:0, ifd:1, exw:0, exm:0, exb:0,
            mw:0, md:1, ww:0, rs:0, rt:0, exa:0, ma:0, wa:0, exp:'0};

      t = d; t.ext = 1;
      t.exp = e(1,1,1,1,1,1,1,1,1,1,0,0,0); vecs.push_back(t);
      t = d; t.exp = e(0,0,0,0,0,0,0,0,0,0,0,0,0); vecs.push_back(t);
      t = d; t.md = 0;
      t.exp = e(1,0,1,0,1,0,1,1,0,0,0,0,0); vecs.push_back(t);
      t = d; t.ifd = 0;
      t.exp = e(1,1,0,0,0,0,0,0,0,0,0,0,0); vecs.push_back(t);
      t = d; t.ifd = 0; t.br = 1;
      t.exp = e(1,1,1,1,0,0,0,0,0,0,0,0,0); vecs.push_back(t);
      t = d; t.urs = 1; t.rs = 3; t.exw = 1; t.exm = 1; t.exa = 3;
      t.exp = e(1,0,1,1,0,0,0,0,0,0,0,0,0); vecs.push_back(t);
      t = d; t.urt = 1; t.rt = 4; t.exw = 1; t.exa = 4;
      t.exp = FWD ? e(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b01)
                  : e(1,0,1,1,0,0,0,0,0,0,0,0,0);
      vecs.push_back(t);
      t = d; t.urs = 1; t.rs = 6; t.mw = 1; t.ma = 6;
      t.exp = FWD ? e(0,0,0,0,0,0,0,0,0,0,0,2'b10,2'b00)
                  : e(1,0,1,1,0,0,0,0,0,0,0,0,0);
      vecs.push_back(t);
      t = d; t.urs = 1; t.rs = 7; t.urt = 1; t.rt = 7; t.ww = 1; t.wa = 7;
      t.exp = FWD ? e(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b11)
                  : e(1,0,1,1,0,0,0,0,0,0,0,0,0);
      vecs.push_back(t);
      t = d; t.urs = 1; t.rs = 8; t.exw = 1; t.exa = 8;
      t.mw = 1; t.ma = 8; t.ww = 1; t.wa = 8;
      t.exp = FWD ? e(0,0,0,0,0,0,0,0,0,0,0,2'b01,2'b00)
                  : e(1,0,1,1,0,0,0,0,0,0,0,0,0);
      vecs.push_back(t);
      t = d; t.urt = 1; t.rt = 9; t.mw = 1; t.ma = 9; t.ww = 1; t.wa = 9;
      t.exp = FWD ? e(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b10)
                  : e(1,0,1,1,0,0,0,0,0,0,0,0,0);
      vecs.push_back(t);
      t = d; t.urs = 1; t.urt = 1; t.exw = 1; t.exm = 1;
      t.mw = 1; t.ww = 1;
      t.exp = e(0,0,0,0,0,0,0,0,0,0,0,0,0); vecs.push_back(t);
      t = d; t.rs = 3; t.exw = 1; t.exm = 1; t.exa = 3;
      t.exp = e(0,0,0,0,0,0,0,0,0,0,0,0,0); vecs.push_back(t);
      t = d; t.exb = 1;
      t.exp = e(0,1,0,0,0,0,0,0,0,0,1,0,0); vecs.push_back(t);
      t = d; t.ext = 1; t.urs = 1; t.rs = 6; t.mw = 1; t.ma = 6;
      t.exp = e(1,1,1,1,1,1,1,1,1,1,0, FWD ? 2'b10 : 2'b00, 2'b00);
      vecs.push_back(t);

      // Reset state
      rst_n = 1'b0;
      apply(d);
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_branch", 32'(if_branch), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         apply(vecs[i]);
         #1;
         chk($sformatf("vec%0d", i), 32'(got()), 32'(vecs[i].exp));
      end

      // Load-use: stall one cycle, then MEM supplies the value
      @(negedge clk); apply(d);
      uses_rs = 1; rs_addr = 3; ex_wb = 1; ex_mem = 1; ex_wa = 3;
      #1;
      chk("lu_stall", 32'({dec_stall, dec_smash}), 32'b11);
      @(negedge clk);
      ex_wb = 0; ex_mem = 0; ex_wa = 0; mem_wb = 1; mem_wa = 3;
      #1;
      chk("lu_after", 32'({dec_stall, dec_smash, fwd_rs}),
          FWD ? 32'b0010 : 32'b1100);

      // Long-latency saturation on r5
      @(negedge clk); apply(d);
      dec_ll = 1; dec_wa = 5;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk($sformatf("ll_issue%0d", k), 32'(dec_stall), 32'd0);
      end
      @(negedge clk); #1;
      chk("ll_full", 32'({dec_stall, dec_smash, busy}), 32'b111);
      @(negedge clk); #1;
      chk("ll_full_hold", 32'(dec_stall), 32'd1);
      ret_v = 1; ret_a = 5;
      @(negedge clk); ret_v = 0; #1;
      chk("ll_release", 32'(dec_stall), 32'd0);
      @(negedge clk);
      dec_ll = 0; uses_rs = 1; rs_addr = 5; ret_v = 1; ret_a = 5;
      #1;
      chk("ll_read_stall", 32'(dec_stall), 32'd1);
      repeat (3) @(negedge clk);
      #1;
      chk("ll_drained", 32'({busy, dec_stall}), 32'b00);
      @(negedge clk); #1;
      chk("ll_zero_dec", 32'(busy), 32'd0);

      // Same-cycle issue and retire on r7
      @(negedge clk); apply(d);
      dec_ll = 1; dec_wa = 7;
      @(negedge clk); ret_v = 1; ret_a = 7;
      @(negedge clk);
      dec_ll = 0; ret_v = 0; uses_rs = 1; rs_addr = 7;
      #1;
      chk("same_cycle", 32'({dec_stall, dec_smash, busy}), 32'b111);
      ret_v = 1;
      @(negedge clk); ret_v = 0; #1;
      chk("r7_retired", 32'({busy, dec_stall}), 32'b00);

      // Branch held while IMEM is busy
      @(negedge clk); apply(d);
      ex_br = 1; ex_tgt = 32'h40; if_done = 0;
      #1;
      chk("br_live", 32'({if_branch, if_smash}), 32'b11);
      chk("br_live_tgt", if_tgt, 32'h40);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         ex_br = 0; ex_tgt = 32'h99;
         #1;
         chk($sformatf("br_hold%0d", k), 32'(if_branch), 32'd1);
         chk($sformatf("br_hold_tgt%0d", k), if_tgt, 32'h40);
      end
      @(negedge clk); if_done = 1; #1;
      chk("br_release", 32'({if_branch, if_stall, if_smash}), 32'b101);
      chk("br_release_tgt", if_tgt, 32'h40);
      @(negedge clk); #1;
      chk("br_cleared", 32'({if_branch, if_smash}), 32'b00);
      @(negedge clk); ex_br = 1; ex_tgt = 32'h10; if_done = 0;
      @(negedge clk); ex_tgt = 32'h80; if_done = 1; #1;
      chk("br_live_prio", if_tgt, 32'h80);
      @(negedge clk); apply(d); #1;
      chk("br_prio_clr", 32'({if_branch, if_smash}), 32'b00);

      // Reset mid-operation discards counts and latch
      dec_ll = 1; dec_wa = 9;
      @(negedge clk); ex_br = 1; ex_tgt = 32'h55; if_done = 0;
      @(negedge clk); dec_ll = 0; ex_br = 0; #1;
      chk("pre_reset", 32'({busy, if_branch}), 32'b11);
      rst_n = 0; #1;
      chk("async_reset", 32'({busy, if_branch}), 32'b00);
      @(negedge clk);
      rst_n = 1; if_done = 1; uses_rs = 1; rs_addr = 9; #1;
      chk("post_reset", 32'({dec_stall, busy, if_smash}), 32'b000);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
